// File: rtl/prog_encoder_if.sv
// Request channel between the host loader and the instruction encoder:
// one symbolic instruction per valid/ready handshake.
interface prog_encoder_if;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] mnemonic;
    logic [2:0] f_a;
    logic [2:0] f_b;
    logic [1:0] f_c;

    modport master (output in_valid, mnemonic, f_a, f_b, f_c, input in_ready);
    modport slave  (input in_valid, mnemonic, f_a, f_b, f_c, output in_ready);
endinterface

// File: rtl/prog_encoder.sv
// Program loader: packs symbolic instructions into 9-bit words and writes them
// to instruction memory at consecutive addresses from 0 until HALT or an error.
module prog_encoder #(
    parameter int instr_width = 9,
    parameter int addr_width  = 8,
    parameter int depth       = 256
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    prog_encoder_if.slave          req,
    output logic                   imem_we,
    output logic [addr_width-1:0]  imem_addr,
    output logic [instr_width-1:0] imem_wdata,
    output logic [addr_width:0]    count,
    output logic                   done,
    output logic                   error,
    output logic [1:0]             err_code
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE, S_ERR} state_t;

    typedef enum logic [3:0] {
        M_AND, M_SLT, M_OR, M_JR, M_LW, M_SW, M_ADD, M_ADDI,
        M_SUB, M_TR, M_BEQ, M_SRL, M_SRA, M_SLL, M_HALT, M_ILL
    } mnemonic_t;

    localparam logic [1:0]          ERR_NONE  = 2'd0;
    localparam logic [1:0]          ERR_ILL   = 2'd1;
    localparam logic [1:0]          ERR_RANGE = 2'd2;
    localparam logic [1:0]          ERR_OVF   = 2'd3;
    localparam logic [addr_width:0] LAST_ADDR = (addr_width + 1)'(depth - 1);

    state_t                 r_state;
    logic                   r_we;
    logic [addr_width-1:0]  r_addr;
    logic [instr_width-1:0] r_wdata;
    logic [addr_width:0]    r_count;
    logic                   r_done;
    logic                   r_error;
    logic [1:0]             r_err_code;

    mnemonic_t              w_mn;
    logic [1:0]             w_a;
    logic [1:0]             w_b;
    logic [instr_width-1:0] w_word;
    logic [1:0]             w_req_err;
    logic                   w_accept;

    assign w_mn     = mnemonic_t'(req.mnemonic);
    assign w_a      = req.f_a[1:0];
    assign w_b      = req.f_b[1:0];
    assign w_accept = req.in_valid && req.in_ready;

    // in_ready is decoded from state rather than registered so accepts can run back-to-back.
    assign req.in_ready = (r_state == S_LOAD);

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        w_word    = '0;
        w_req_err = ERR_NONE;
        case (w_mn)
            M_AND, M_SLT, M_OR: w_word = {3'b000, w_a, w_b, req.mnemonic[1:0]};
            M_JR:               w_word = {3'b000, w_a, 2'b00, 2'b11};
            M_LW:               w_word = {3'b001, w_a, w_b, 2'b00};
            M_SW:               w_word = {3'b001, w_a, w_b, 2'b01};
            M_ADD:              w_word = {3'b010, w_a, w_b, req.f_c};
            M_ADDI:             w_word = {3'b011, w_a, w_b, req.f_c};
            M_SUB:              w_word = {3'b100, w_a, w_b, req.f_c};
            M_TR:               w_word = {3'b101, req.f_a, req.f_b};
            M_BEQ:              w_word = {3'b110, w_a, w_b, 2'b00};
            M_SRL:              w_word = {3'b111, w_a, w_b, 2'b00};
            M_SRA:              w_word = {3'b111, w_a, w_b, 2'b01};
            M_SLL:              w_word = {3'b111, w_a, w_b, 2'b10};
            M_HALT:             w_word = {3'b111, 2'b00, 2'b00, 2'b11};
            default:            w_word = '0;
        endcase

        if (w_mn == M_ILL) begin
            w_req_err = ERR_ILL;
        end else if (w_mn == M_JR) begin
            if (req.f_a[2]) w_req_err = ERR_RANGE;
        end else if (w_mn != M_TR && w_mn != M_HALT) begin
            if (req.f_a[2] || req.f_b[2]) w_req_err = ERR_RANGE;
        end
    end

    // NOTE: state and outputs update with non-blocking assignments under an async reset,
    // so all registers see the same pre-edge values and reset takes effect immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_count    <= '0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_err_code <= ERR_NONE;
        end else begin
            r_we <= 1'b0;
            case (r_state)
                S_LOAD: begin
                    if (w_accept) begin
                        if (w_req_err != ERR_NONE) begin
                            r_state    <= S_ERR;
                            r_error    <= 1'b1;
                            r_err_code <= w_req_err;
                        end else begin
                            r_we    <= 1'b1;
                            r_addr  <= r_count[addr_width-1:0];
                            r_wdata <= w_word;
                            r_count <= r_count + 1'b1;
                            if (w_mn == M_HALT) begin
                                r_state <= S_DONE;
                                r_done  <= 1'b1;
                            end else if (r_count == LAST_ADDR) begin
                                // Last free word is still written before aborting.
                                r_state    <= S_ERR;
                                r_error    <= 1'b1;
                                r_err_code <= ERR_OVF;
                            end
                        end
                    end
                end
                default: begin
                    if (start) begin
                        r_state    <= S_LOAD;
                        r_count    <= '0;
                        r_done     <= 1'b0;
                        r_error    <= 1'b0;
                        r_err_code <= ERR_NONE;
                    end
                end
            endcase
        end
    end

    assign imem_we    = r_we;
    assign imem_addr  = r_addr;
    assign imem_wdata = r_wdata;
    assign count      = r_count;
    assign done       = r_done;
    assign error      = r_error;
    assign err_code   = r_err_code;

endmodule

// File: tb/tb_prog_encoder.sv
// Self-checking bench for prog_encoder: directed sessions compared every cycle
// against a behavioural model, plus hand-computed literal expectations.
module tb_prog_encoder;

    localparam int AW    = 8;
    localparam int IW    = 9;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          start = 1'b0;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [IW-1:0] imem_wdata;
    logic [AW:0]   count;
    logic          done;
    logic          error;
    logic [1:0]    err_code;

    int n_checks = 0;
    int n_fail   = 0;

    prog_encoder_if req_if ();

    prog_encoder #(.instr_width(IW), .addr_width(AW), .depth(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .req       (req_if),
        .imem_we   (imem_we),
        .imem_addr (imem_addr),
        .imem_wdata(imem_wdata),
        .count     (count),
        .done      (done),
        .error     (error),
        .err_code  (err_code)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: session flags plus a write counter.
    bit m_load = 0, m_done = 0, m_err = 0, m_we = 0;
    int m_count = 0, m_code = 0, m_addr = 0, m_wdata = 0;

    function automatic void model_encode(input int mn, input int a, input int b, input int c,
                                         output int w, output int code);
        int opc, low, a2, b2;
        code = 0;
        if (mn == 15) code = 1;
        else if (mn != 9 && mn != 14 && (a > 3 || (mn != 3 && b > 3))) code = 2;
        a2 = a % 4;
        b2 = b % 4;
        opc = 0;
        low = 0;
        if (mn <= 3) begin opc = 0; low = mn; if (mn == 3) b2 = 0; end
        else if (mn <= 5) begin opc = 1; low = mn - 4; end
        else if (mn == 6) begin opc = 2; low = c; end
        else if (mn == 7) begin opc = 3; low = c; end
        else if (mn == 8) begin opc = 4; low = c; end
        else if (mn == 10) begin opc = 6; low = 0; end
        else if (mn >= 11 && mn <= 14) begin
            opc = 7; low = mn - 11;
            if (mn == 14) begin a2 = 0; b2 = 0; end
        end
        if (mn == 9) w = 5 * 64 + a * 8 + b;
        else         w = opc * 64 + a2 * 16 + b2 * 4 + low;
    endfunction

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_load = 0; m_done = 0; m_err = 0; m_we = 0;
            m_count = 0; m_code = 0;
        end else begin
            m_we = 0;
            if (!m_load) begin
                if (start) begin
                    m_load = 1; m_count = 0; m_done = 0; m_err = 0; m_code = 0;
                end
            end else if (req_if.in_valid) begin
                int w, code;
                model_encode(int'(req_if.mnemonic), int'(req_if.f_a), int'(req_if.f_b),
                             int'(req_if.f_c), w, code);
                if (code != 0) begin
                    m_load = 0; m_err = 1; m_code = code;
                end else begin
                    m_we = 1; m_addr = m_count; m_wdata = w; m_count++;
                    if (req_if.mnemonic == 4'd14) begin
                        m_load = 0; m_done = 1;
                    end else if (m_count == DEPTH) begin
                        m_load = 0; m_err = 1; m_code = 3;
                    end
                end
            end
        end
    end

    // Compare process: DUT against model on every falling edge.
    initial forever begin
        @(negedge clk);
        check("m_in_ready", 32'(req_if.in_ready), 32'(m_load));
        check("m_imem_we", 32'(imem_we), 32'(m_we));
        if (m_we) begin
            check("m_imem_addr", 32'(imem_addr), 32'(m_addr));
            check("m_imem_wdata", 32'(imem_wdata), 32'(m_wdata));
        end
        check("m_count", 32'(count), 32'(m_count));
        check("m_done", 32'(done), 32'(m_done));
        check("m_error", 32'(error), 32'(m_err));
        check("m_err_code", 32'(err_code), 32'(m_code));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Presents a request for one edge; in_valid stays high until drop().
    task automatic send(input int mn, input int a, input int b, input int c);
        req_if.in_valid = 1'b1;
        req_if.mnemonic = 4'(mn);
        req_if.f_a      = 3'(a);
        req_if.f_b      = 3'(b);
        req_if.f_c      = 2'(c);
        tick();
    endtask

    task automatic drop();
        req_if.in_valid = 1'b0;
    endtask

    task automatic expect_write(input string name, input int addr, input int word, input int cnt);
        check({name, "_we"}, 32'(imem_we), 32'd1);
        check({name, "_addr"}, 32'(imem_addr), 32'(addr));
        check({name, "_wdata"}, 32'(imem_wdata), 32'(word));
        check({name, "_count"}, 32'(count), 32'(cnt));
    endtask

    task automatic expect_err(input string name, input int code, input int cnt);
        check({name, "_we"}, 32'(imem_we), 32'd0);
        check({name, "_error"}, 32'(error), 32'd1);
        check({name, "_code"}, 32'(err_code), 32'(code));
        check({name, "_count"}, 32'(count), 32'(cnt));
        check({name, "_ready"}, 32'(req_if.in_ready), 32'd0);
    endtask

    initial begin
        req_if.in_valid = 1'b0;
        req_if.mnemonic = '0;
        req_if.f_a      = '0;
        req_if.f_b      = '0;
        req_if.f_c      = '0;
        #2 rst_n = 1'b0;
        tick();
        tick();
        check("rst_ready", 32'(req_if.in_ready), 32'd0);
        check("rst_we", 32'(imem_we), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_flags", {29'd0, done, err_code}, 32'd0);
        rst_n = 1'b1;
        tick();

        pulse_start();
        check("start_ready", 32'(req_if.in_ready), 32'd1);
        send(6, 1, 2, 3);
        expect_write("add", 0, 9'h09B, 1);
        send(7, 2, 1, 3);
        expect_write("addi", 1, 9'h0E7, 2);
        send(9, 5, 2, 0);
        expect_write("tr", 2, 9'h16A, 3);
        send(14, 0, 0, 0);
        expect_write("halt", 3, 9'h1C3, 4);
        check("halt_done", 32'(done), 32'd1);
        check("halt_ready", 32'(req_if.in_ready), 32'd0);
        check("halt_error", 32'(error), 32'd0);

        // in_valid held high in DONE must not write.
        send(6, 1, 1, 1);
        tick();
        tick();
        check("done_hold_we", 32'(imem_we), 32'd0);
        check("done_hold_count", 32'(count), 32'd4);
        drop();

        pulse_start();
        check("restart_clear", {23'd0, count}, 32'd0);
        send(0, 3, 3, 0);
        expect_write("and", 0, 9'h03C, 1);
        send(15, 0, 0, 0);
        expect_err("illegal", 1, 1);
        drop();

        pulse_start();
        send(6, 4, 0, 0);
        expect_err("range_a", 2, 0);
        drop();

        pulse_start();
        send(3, 1, 4, 0);
        expect_write("jr_fb_ignored", 0, 9'h013, 1);
        send(1, 0, 4, 0);
        expect_err("range_b", 2, 1);
        drop();

        pulse_start();
        send(15, 4, 4, 0);
        expect_err("prio_ill", 1, 0);
        drop();

        // Overflow: fourth non-HALT word lands at depth-1.
        pulse_start();
        send(8, 1, 1, 2);
        expect_write("sub", 0, 9'h116, 1);
        send(10, 2, 3, 1);
        expect_write("beq", 1, 9'h1AC, 2);
        send(4, 1, 2, 0);
        expect_write("lw", 2, 9'h058, 3);
        send(12, 3, 0, 0);
        expect_write("sra_ovf", 3, 9'h1F1, 4);
        check("ovf_error", 32'(error), 32'd1);
        check("ovf_code", 32'(err_code), 32'd3);
        check("ovf_ready", 32'(req_if.in_ready), 32'd0);
        drop();
        tick();

        // start during LOAD is ignored.
        pulse_start();
        start = 1'b1;
        send(6, 0, 0, 0);
        start = 1'b0;
        expect_write("start_in_load", 0, 9'h080, 1);
        send(6, 1, 1, 1);
        expect_write("add2", 1, 9'h095, 2);
        send(7, 1, 0, 2);
        expect_write("addi2", 2, 9'h0D2, 3);

        // Reset right after an accept drops the pending strobe.
        rst_n = 1'b0;
        #1;
        check("midrst_we", 32'(imem_we), 32'd0);
        check("midrst_count", 32'(count), 32'd0);
        check("midrst_addr", 32'(imem_addr), 32'd0);
        check("midrst_wdata", 32'(imem_wdata), 32'd0);
        check("midrst_ready", 32'(req_if.in_ready), 32'd0);
        drop();
        tick();
        rst_n = 1'b1;
        tick();
        pulse_start();
        send(9, 7, 7, 0);
        expect_write("reload", 0, 9'h17F, 1);
        drop();
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
